mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Memory-stage data-memory access controller, directly downstream of the byte-enable generator. It takes one load/store per request plus the 4-bit byte-enable mask, checks alignment and mask consistency, and lane-aligns store data. It runs a req/ack transaction on the data-memory bus, stalling the pipeline until completion, and returns sign- or zero-extended load data.

## Interface
- `TIMEOUT`, 255: BUSY cycles without `mem_ack` before abort. Range 1–255.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 1: MEM-stage access valid.
- `we` in 1: 1 = store, 0 = load.
- `st_signal` in 2: access size. 00 = word, 01 = half, 10 = byte, 11 = illegal.
- `ld_sign` in 1: 1 = sign-extend loads, 0 = zero-extend.
- `addr` in 32: byte address.
- `wdata` in 32: store data, right-justified.
- `be` in 4: byte-enable mask from the BE stage.
- `stall` out 1: hold the pipeline.
- `rdata` out 32: extended load result. Valid when `done` = 1.
- `done` out 1: one-cycle completion pulse.
- `misalign` out 1: one-cycle illegal-access pulse.
- `bus_err` out 1: one-cycle timeout pulse.
- `mem_req` out 1: bus request.
- `mem_we` out 1: bus write.
- `mem_addr` out 30: word address, `addr[31:2]`.
- `mem_be` out 4: bus byte lanes.
- `mem_wdata` out 32: lane-aligned store data.
- `mem_ack` in 1: bus acknowledge. `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 32: bus read word.

## Operation
- States: IDLE, BUSY, RESP, ERR.
- Reset values: state IDLE. All outputs 0, including `rdata`, `mem_addr`, `mem_be` and `mem_wdata`.
- Legality is computed combinationally in IDLE:
  - `st_signal` != 11.
  - Word requires `addr[1:0]` = 00.
  - Half requires `addr[0]` = 0.
  - `be` must equal the expected mask:
    - word: 1111
    - half: 0011 at offset 00, 1100 at offset 10
    - byte: 0001 << `addr[1:0]`
- IDLE transitions:
  - `req` and legal: register bus fields, go to BUSY.
  - `req` and illegal: go to ERR. No bus access.
- BUSY:
  - `mem_req` = 1. Fields are held stable until `mem_ack` is sampled.
  - A counter increments each BUSY cycle.
  - `mem_ack` = 1: register formatted `rdata`, go to RESP.
  - Counter reaches `TIMEOUT` with no ack: go to ERR with `bus_err`.
  - Ack and timeout on the same edge: ack wins.
- RESP:
  - `done` = 1.
  - `rdata` = formatted load data, or 0 for stores.
  - Return to IDLE.
  - `req` is ignored, because it still belongs to the same instruction.
- ERR:
  - `misalign` = 1 or `bus_err` = 1.
  - `done` = 0.
  - Return to IDLE.
- Store data alignment:
  - word: `wdata`.
  - half: `{wdata[15:0], wdata[15:0]}`.
  - byte: `{4{wdata[7:0]}}`.
- `mem_be` = `be` for both loads and stores.
- Load formatting:
  - byte: lane `addr[1:0]`, selecting `mem_rdata[8*lane+7 : 8*lane]`.
  - half: `mem_rdata[31:16]` if `addr[1]` = 1, else `mem_rdata[15:0]`.
  - The selected field is extended to 32 bits per `ld_sign`.
- `mem_ack` outside BUSY is ignored.
- `stall` = (IDLE and `req`) or BUSY. It is combinational and is 0 in RESP and ERR.

## Timing
- Minimum latency, with request in cycle 0:
  - cycle 0: IDLE, `stall` = 1.
  - cycle 1: `mem_req` = 1; `mem_ack` earliest here.
  - cycle 2: RESP, `done` = 1, `stall` = 0, `mem_req` = 0.
- Each extra wait cycle without ack adds one cycle.
- Illegal access: ERR in cycle 1 with `misalign` = 1. `mem_req` is never raised.
- Timeout: ERR is entered on the edge where the BUSY counter equals `TIMEOUT`. `mem_req` drops in the ERR cycle.
- `mem_req` deasserts in the cycle after ack.
- Back-to-back requests: the next `req` is accepted in the IDLE cycle following RESP or ERR. The minimum cadence is 3 cycles per access.
- Reset mid-transaction: `mem_req` drops immediately (asynchronous). A pending ack is lost and no `done` is produced.

## Structure
- Shared package holds:
  - size encodings: `SZ_WORD` = 2'b00, `SZ_HALF` = 2'b01, `SZ_BYTE` = 2'b10.
  - state encoding.
  - the expected-mask function, reused by the BE stage checker.
- Sub-module `ld_format`: combinational load lane select plus sign/zero extend. Inputs are `mem_rdata`, `addr[1:0]`, `st_signal` and `ld_sign`.
- The FSM, timeout counter and store alignment stay in the top module.

## Test plan
- Byte store, `addr` = 0x103, `wdata` = 0x000000A5, `be` = 1000, ack in cycle 1:
  - `mem_addr` = 0x40, `mem_be` = 1000, `mem_wdata` = 0xA5A5A5A5.
  - `done` in cycle 2; `stall` high for 2 cycles.
- Signed half load, `addr` = 0x22, `be` = 1100, `mem_rdata` = 0x8001_1234, ack after 3 wait cycles:
  - `rdata` = 0xFFFF8001.
  - With `ld_sign` = 0: `rdata` = 0x00008001.
- Word load at `addr` = 0x06 with `be` = 1111:
  - `misalign` pulse in cycle 1, `mem_req` never raised, `stall` = 0 in cycle 1.
- Byte load at `addr` = 0x01 with mismatched `be` = 0001:
  - `misalign` = 1; no bus activity.
- `TIMEOUT` = 4, no ack:
  - `mem_req` high for 4 cycles, then `bus_err` pulse with `mem_req` = 0.
  - Ack arriving on the 4th cycle instead produces `done`, not `bus_err`.
- Assert `rst_n` = 0 while in BUSY:
  - All outputs 0 immediately; after release, a new request completes normally.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the data-memory access path: size encodings, FSM states
// and the expected byte-enable mask also used by the BE-stage checker.
package mem_access_ctrl_pkg;

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2,
      ST_ERR  = 2'd3
   } state_e;

   // Mask the BE stage must have produced for this size/offset; 0 for an illegal size.
   function automatic logic [3:0] expected_be(input logic [1:0] size, input logic [1:0] off);
      logic [3:0] mask;
      mask = 4'b0000;
      case (size)
         SZ_WORD: mask = 4'b1111;
         SZ_HALF: mask = off[1] ? 4'b1100 : 4'b0011;
         SZ_BYTE: mask = 4'b0001 << off;
         default: mask = 4'b0000;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/mem_access_ctrl_ld_format.sv
// Load formatting: picks the byte/half lane out of the bus word and
// sign- or zero-extends it to 32 bits. Words pass through unchanged.
module ld_format
   import mem_access_ctrl_pkg::*;
(
   input  logic [31:0] mem_rdata,
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  st_signal,
   input  logic        ld_sign,
   output logic [31:0] ld_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (addr_lo)
         2'd0:    byte_sel = mem_rdata[7:0];
         2'd1:    byte_sel = mem_rdata[15:8];
         2'd2:    byte_sel = mem_rdata[23:16];
         default: byte_sel = mem_rdata[31:24];
      endcase
      half_sel = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (st_signal)
         SZ_HALF: ld_data = {{16{ld_sign & half_sel[15]}}, half_sel};
         SZ_BYTE: ld_data = {{24{ld_sign & byte_sel[7]}}, byte_sel};
         default: ld_data = mem_rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: legality check, store lane alignment,
// req/ack bus transaction with timeout, and formatted load return.
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        we,
   input  logic [1:0]  st_signal,
   input  logic        ld_sign,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [3:0]  be,
   output logic        stall,
   output logic [31:0] rdata,
   output logic        done,
   output logic        misalign,
   output logic        bus_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [29:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata
);

   localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT);

   state_e      state_reg, state_next;
   logic [7:0]  cnt_reg, cnt_next;
   logic        err_bus_reg, err_bus_next;
   logic [1:0]  size_reg;
   logic [1:0]  off_reg;
   logic        sign_reg;
   logic        mem_we_reg;
   logic [29:0] mem_addr_reg;
   logic [3:0]  mem_be_reg;
   logic [31:0] mem_wdata_reg;
   logic [31:0] rdata_reg;

   logic        aligned;
   logic        legal;
   logic        accept;
   logic        ack_take;
   logic [31:0] wdata_aligned;
   logic [31:0] ld_data;

   // Request legality and store lane replication, evaluated against the live request.
   always_comb begin
      case (st_signal)
         SZ_WORD: aligned = (addr[1:0] == 2'b00);
         SZ_HALF: aligned = ~addr[0];
         SZ_BYTE: aligned = 1'b1;
         default: aligned = 1'b0;
      endcase
      legal = aligned && (be == expected_be(st_signal, addr[1:0]));
      case (st_signal)
         SZ_HALF: wdata_aligned = {wdata[15:0], wdata[15:0]};
         SZ_BYTE: wdata_aligned = {4{wdata[7:0]}};
         default: wdata_aligned = wdata;
      endcase
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      err_bus_next = err_bus_reg;
      accept       = 1'b0;
      ack_take     = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (req) begin
               if (legal) begin
                  accept     = 1'b1;
                  cnt_next   = 8'd0;
                  state_next = ST_BUSY;
               end else begin
                  err_bus_next = 1'b0;
                  state_next   = ST_ERR;
               end
            end
         end
         ST_BUSY: begin
            // An ack on the timeout edge still completes the access.
            if (mem_ack) begin
               ack_take   = 1'b1;
               state_next = ST_RESP;
            end else if (({1'b0, cnt_reg} + 9'd1) == TIMEOUT_LIM) begin
               err_bus_next = 1'b1;
               state_next   = ST_ERR;
            end else begin
               cnt_next = cnt_reg + 8'd1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         cnt_reg       <= 8'd0;
         err_bus_reg   <= 1'b0;
         size_reg      <= SZ_WORD;
         off_reg       <= 2'b00;
         sign_reg      <= 1'b0;
         mem_we_reg    <= 1'b0;
         mem_addr_reg  <= 30'd0;
         mem_be_reg    <= 4'd0;
         mem_wdata_reg <= 32'd0;
         rdata_reg     <= 32'd0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         err_bus_reg <= err_bus_next;
         if (accept) begin
            size_reg      <= st_signal;
            off_reg       <= addr[1:0];
            sign_reg      <= ld_sign;
            mem_we_reg    <= we;
            mem_addr_reg  <= addr[31:2];
            mem_be_reg    <= be;
            mem_wdata_reg <= wdata_aligned;
         end
         if (ack_take) begin
            rdata_reg <= mem_we_reg ? 32'd0 : ld_data;
         end
      end
   end

   ld_format u_ld_format (
      .mem_rdata (mem_rdata),
      .addr_lo   (off_reg),
      .st_signal (size_reg),
      .ld_sign   (sign_reg),
      .ld_data   (ld_data)
   );

   assign stall     = ((state_reg == ST_IDLE) && req) || (state_reg == ST_BUSY);
   assign done      = (state_reg == ST_RESP);
   assign misalign  = (state_reg == ST_ERR) && !err_bus_reg;
   assign bus_err   = (state_reg == ST_ERR) && err_bus_reg;
   assign mem_req   = (state_reg == ST_BUSY);
   assign mem_we    = mem_we_reg;
   assign mem_addr  = mem_addr_reg;
   assign mem_be    = mem_be_reg;
   assign mem_wdata = mem_wdata_reg;
   assign rdata     = rdata_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: directed cases plus random accesses,
// expected responses and bus fields queued by the driver and checked by monitors.
module tb_mem_access_ctrl;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req;
   logic        we;
   logic [1:0]  st_signal;
   logic        ld_sign;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  be;
   logic        stall;
   logic [31:0] rdata;
   logic        done;
   logic        misalign;
   logic        bus_err;
   logic        mem_req;
   logic        mem_we;
   logic [29:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   always #5 clk = ~clk;

   mem_access_ctrl #(.TIMEOUT(TO)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .we        (we),
      .st_signal (st_signal),
      .ld_sign   (ld_sign),
      .addr      (addr),
      .wdata     (wdata),
      .be        (be),
      .stall     (stall),
      .rdata     (rdata),
      .done      (done),
      .misalign  (misalign),
      .bus_err   (bus_err),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_be    (mem_be),
      .mem_wdata (mem_wdata),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata)
   );

   // kind: 0 = done, 1 = misalign, 2 = bus_err
   typedef struct {
      int          kind;
      logic [31:0] rdata;
   } resp_t;

   typedef struct {
      logic        we;
      logic [29:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } bus_t;

   resp_t resp_q[$];
   bus_t  bus_q[$];
   int    errors = 0;
   int    checks = 0;
   int    resp_seen = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic int size_bytes(input logic [1:0] sz);
      case (sz)
         2'b00:   return 4;
         2'b01:   return 2;
         2'b10:   return 1;
         default: return 0;
      endcase
   endfunction

   function automatic logic [3:0] ref_mask(input logic [31:0] a, input int n);
      int m;
      m = ((1 << n) - 1) << (a % 4);
      return 4'(m);
   endfunction

   function automatic bit ref_legal(input logic [1:0] sz, input logic [31:0] a, input logic [3:0] b);
      int n;
      n = size_bytes(sz);
      if (n == 0) return 1'b0;
      if ((a % n) != 0) return 1'b0;
      return (b == ref_mask(a, n));
   endfunction

   function automatic logic [31:0] ref_store(input logic [31:0] w, input int n);
      logic [63:0] f;
      f = {32'd0, w} & ((64'd1 << (8 * n)) - 64'd1);
      if (n == 4) return w;
      if (n == 2) return 32'(f * 64'h0000_0000_0001_0001);
      return 32'(f * 64'h0000_0000_0101_0101);
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] a,
                                            input int n, input logic sgn);
      logic [31:0] f;
      logic [31:0] m;
      int          sh;
      if (n == 4) return word;
      sh = 8 * int'(a % 4);
      m  = (32'd1 << (8 * n)) - 32'd1;
      f  = (word >> sh) & m;
      if (sgn && f[8 * n - 1]) f = f | ~m;
      return f;
   endfunction

   // Monitors: bus fields on each rising mem_req, responses on done/misalign/bus_err.
   logic  mem_req_prev = 1'b0;
   bus_t  mon_b;
   resp_t mon_r;
   int    kind_act;

   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_req && !mem_req_prev) begin
            if (bus_q.size() == 0) begin
               check("bus_unexpected_req", 32'd1, 32'd0);
            end else begin
               mon_b = bus_q.pop_front();
               check("mem_we", {31'd0, mem_we}, {31'd0, mon_b.we});
               check("mem_addr", {2'd0, mem_addr}, {2'd0, mon_b.addr});
               check("mem_be", {28'd0, mem_be}, {28'd0, mon_b.be});
               check("mem_wdata", mem_wdata, mon_b.wdata);
            end
         end
         if (done || misalign || bus_err) begin
            check("resp_onehot", 32'(done) + 32'(misalign) + 32'(bus_err), 32'd1);
            kind_act = done ? 0 : (misalign ? 1 : 2);
            if (resp_q.size() == 0) begin
               check("resp_unexpected", 32'd1, 32'd0);
            end else begin
               mon_r = resp_q.pop_front();
               check("resp_kind", 32'(kind_act), 32'(mon_r.kind));
               if (done) check("rdata", rdata, mon_r.rdata);
            end
            resp_seen++;
            $display("txn %0d: kind=%0d rdata=0x%08h", resp_seen, kind_act, rdata);
         end
      end
      mem_req_prev = mem_req;
   end

   // One access, inputs held for the whole transaction as a stalled pipeline would.
   task automatic run_txn(input logic t_we, input logic [1:0] t_size, input logic t_sign,
                          input logic [31:0] t_addr, input logic [31:0] t_wdata,
                          input logic [3:0] t_be, input int t_wait,
                          input logic [31:0] t_rword, input bit t_noack);
      int    n;
      bit    legal;
      int    exp_end;
      int    ack_cyc;
      int    req_cnt;
      int    stall_cnt;
      int    k;
      bit    fin;
      resp_t r;
      bus_t  b;

      n     = size_bytes(t_size);
      legal = ref_legal(t_size, t_addr, t_be);
      r.rdata = 32'd0;
      if (!legal) begin
         r.kind  = 1;
         exp_end = 1;
         ack_cyc = -1;
      end else if (t_noack) begin
         r.kind  = 2;
         exp_end = TO + 1;
         ack_cyc = -1;
      end else begin
         r.kind  = 0;
         r.rdata = t_we ? 32'd0 : ref_load(t_rword, t_addr, n, t_sign);
         exp_end = t_wait + 2;
         ack_cyc = t_wait + 1;
      end
      resp_q.push_back(r);
      if (legal) begin
         b.we    = t_we;
         b.addr  = t_addr[31:2];
         b.be    = t_be;
         b.wdata = ref_store(t_wdata, n);
         bus_q.push_back(b);
      end

      req       = 1'b1;
      we        = t_we;
      st_signal = t_size;
      ld_sign   = t_sign;
      addr      = t_addr;
      wdata     = t_wdata;
      be        = t_be;
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      req_cnt   = 0;
      stall_cnt = 0;
      @(negedge clk);
      if (stall) stall_cnt++;
      if (mem_req) req_cnt++;

      fin = 1'b0;
      k   = 0;
      while (!fin && k < TO + 4) begin
         k++;
         @(posedge clk);
         #1;
         if (k == ack_cyc) begin
            mem_ack   = 1'b1;
            mem_rdata = t_rword;
         end else if (k >= exp_end) begin
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
         end else begin
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
         end
         @(negedge clk);
         if (stall) stall_cnt++;
         if (mem_req) req_cnt++;
         if (done || misalign || bus_err) fin = 1'b1;
      end
      check("end_cycle", 32'(k), 32'(exp_end));
      check("mem_req_cycles", 32'(req_cnt), legal ? 32'(exp_end - 1) : 32'd0);
      check("stall_cycles", 32'(stall_cnt), 32'(exp_end));

      @(posedge clk);
      #1;
      req     = 1'b0;
      mem_ack = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   logic [1:0]  r_size;
   logic [31:0] r_addr;
   logic [3:0]  r_be;
   int          r_n;

   initial begin
      rst_n     = 1'b0;
      req       = 1'b0;
      we        = 1'b0;
      st_signal = 2'b00;
      ld_sign   = 1'b0;
      addr      = 32'd0;
      wdata     = 32'd0;
      be        = 4'd0;
      mem_ack   = 1'b0;
      mem_rdata = 32'd0;

      #12;
      check("rst_stall", {31'd0, stall}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_mem_addr", {2'd0, mem_addr}, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Byte store at 0x103, immediate ack
      run_txn(1'b1, 2'b10, 1'b0, 32'h0000_0103, 32'h0000_00A5, 4'b1000, 0, 32'h0, 1'b0);
      // Signed and unsigned half loads at 0x22 after 3 wait cycles
      run_txn(1'b0, 2'b01, 1'b1, 32'h0000_0022, 32'h0, 4'b1100, 3, 32'h8001_1234, 1'b0);
      run_txn(1'b0, 2'b01, 1'b0, 32'h0000_0022, 32'h0, 4'b1100, 3, 32'h8001_1234, 1'b0);
      // Misaligned word, mismatched byte mask, illegal size
      run_txn(1'b0, 2'b00, 1'b0, 32'h0000_0006, 32'h0, 4'b1111, 0, 32'h0, 1'b0);
      run_txn(1'b0, 2'b10, 1'b0, 32'h0000_0001, 32'h0, 4'b0001, 0, 32'h0, 1'b0);
      run_txn(1'b1, 2'b11, 1'b0, 32'h0000_0000, 32'h0, 4'b1111, 0, 32'h0, 1'b0);
      // Timeout, then ack on the last allowed cycle
      run_txn(1'b0, 2'b00, 1'b0, 32'h0000_1000, 32'h0, 4'b1111, 0, 32'h0, 1'b1);
      run_txn(1'b0, 2'b00, 1'b0, 32'h0000_1004, 32'h0, 4'b1111, TO - 1, 32'hDEAD_BEEF, 1'b0);
      // Half store and signed byte load on lane 3
      run_txn(1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h1234_5678, 4'b1100, 1, 32'h0, 1'b0);
      run_txn(1'b0, 2'b10, 1'b1, 32'h0000_0303, 32'h0, 4'b1000, 0, 32'h80FF_7F01, 1'b0);

      // Reset while BUSY with an ack pending
      bus_q.push_back('{we: 1'b0, addr: 30'h0000_0100, be: 4'b1111, wdata: 32'h0000_0000});
      req       = 1'b1;
      we        = 1'b0;
      st_signal = 2'b00;
      addr      = 32'h0000_0400;
      be        = 4'b1111;
      wdata     = 32'h0;
      idle_cycles(2);
      mem_ack   = 1'b1;
      mem_rdata = 32'h5555_AAAA;
      req       = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_mem_req", {31'd0, mem_req}, 32'd0);
      check("midrst_stall", {31'd0, stall}, 32'd0);
      check("midrst_done", {31'd0, done}, 32'd0);
      check("midrst_rdata", rdata, 32'd0);
      check("midrst_mem_addr", {2'd0, mem_addr}, 32'd0);
      check("midrst_mem_be", {28'd0, mem_be}, 32'd0);
      check("midrst_mem_wdata", mem_wdata, 32'd0);
      check("midrst_mem_we", {31'd0, mem_we}, 32'd0);
      idle_cycles(2);
      @(negedge clk);
      rst_n   = 1'b1;
      mem_ack = 1'b0;
      @(posedge clk);
      #1;
      run_txn(1'b0, 2'b00, 1'b0, 32'h0000_0040, 32'h0, 4'b1111, 1, 32'h0BAD_F00D, 1'b0);

      // Random traffic
      for (int i = 0; i < 120; i++) begin
         r_size = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         r_n    = size_bytes(r_size);
         r_addr = $urandom;
         if (r_n != 0 && $urandom_range(0, 9) < 7) r_addr = r_addr & ~(32'(r_n) - 32'd1);
         r_be   = ($urandom_range(0, 9) < 8) ? ref_mask(r_addr, r_n) : 4'($urandom);
         run_txn(1'($urandom_range(0, 1)), r_size, 1'($urandom_range(0, 1)), r_addr, $urandom,
                 r_be, $urandom_range(0, TO - 1), $urandom, ($urandom_range(0, 9) == 0));
         idle_cycles($urandom_range(0, 2));
      end

      idle_cycles(3);
      check("resp_q_empty", 32'(resp_q.size()), 32'd0);
      check("bus_q_empty", 32'(bus_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
